// File: rtl/otp_access_sequencer.sv
// -----------------------------------------------------------------------------
// otp_access_sequencer
//
// Shares one OTP array controller FSM between two requesters (port 0: host,
// port 1: boot loader). Word requests are arbitrated round-robin. The block
// drives the FSM's mode/column/data inputs, times program pulses and read
// windows, reads back every program, retries failed programs and generates
// the FSM's writing_successful pulse from the verify result.
//
// Ports:
//   clk                     rising-edge clock
//   reset                   asynchronous, active-low reset
//   req[1:0]                per-port request, held until granted
//   we[1:0]                 per-port write (1) / read (0)
//   col0, col1              per-port column index
//   wdata0, wdata1          per-port program data
//   gnt[1:0]                one-cycle grant; request fields captured with it
//   rsp_valid               one-cycle response strobe
//   rsp_id                  port the response belongs to
//   rsp_rdata               read data, or final verify data for a write
//   rsp_err                 verify failed after all retries, or column >= B
//   otp_mode                to FSM: 0 idle, 1 program, 2 read
//   otp_column              to FSM column
//   otp_data_in             to FSM program data
//   otp_writing_successful  to FSM, one-cycle pulse after a passing verify
//   otp_data_out            read data from FSM
// -----------------------------------------------------------------------------
module otp_access_sequencer #(
  parameter int A            = 2,
  parameter int B            = 2,
  parameter int ADDR_WIDTH   = (B > 1) ? $clog2(B) : 1,
  parameter int PULSE_CYCLES = 8,
  parameter int READ_CYCLES  = 4,
  parameter int MAX_RETRY    = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            req,
  input  logic [1:0]            we,
  input  logic [ADDR_WIDTH-1:0] col0,
  input  logic [ADDR_WIDTH-1:0] col1,
  input  logic [A-1:0]          wdata0,
  input  logic [A-1:0]          wdata1,
  output logic [1:0]            gnt,
  output logic                  rsp_valid,
  output logic                  rsp_id,
  output logic [A-1:0]          rsp_rdata,
  output logic                  rsp_err,
  output logic [1:0]            otp_mode,
  output logic [ADDR_WIDTH-1:0] otp_column,
  output logic [A-1:0]          otp_data_in,
  output logic                  otp_writing_successful,
  input  logic [A-1:0]          otp_data_out
);

  localparam int MAX_CYC = (PULSE_CYCLES > READ_CYCLES) ? PULSE_CYCLES : READ_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PROG   = 3'd1,
    VERIFY = 3'd2,
    READ   = 3'd3,
    RESP   = 3'd4
  } state_t;

  state_t                  state_reg,   state_next;
  logic [CNT_W-1:0]        cnt_reg,     cnt_next;
  logic [RETRY_W-1:0]      retry_reg,   retry_next;
  logic                    id_reg,      id_next;
  logic                    last_id_reg, last_id_next;
  logic [ADDR_WIDTH-1:0]   col_reg,     col_next;
  logic [A-1:0]            wd_reg,      wd_next;
  logic [1:0]              gnt_reg,     gnt_next;
  logic                    rsp_valid_reg, rsp_valid_next;
  logic                    rsp_id_reg,    rsp_id_next;
  logic [A-1:0]            rsp_rdata_reg, rsp_rdata_next;
  logic                    rsp_err_reg,   rsp_err_next;
  logic                    wsucc_reg,     wsucc_next;

  // Arbitration: a lone requester wins outright; on a tie the port that was
  // not granted last wins.
  logic                  win;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_col;
  logic [A-1:0]          sel_wd;
  logic                  sel_col_bad;
  logic                  verify_pass;

  always_comb begin
    win = req[1];
    if (req == 2'b11) begin
      win = ~last_id_reg;
    end
  end

  assign sel_we      = win ? we[1]  : we[0];
  assign sel_col     = win ? col1   : col0;
  assign sel_wd      = win ? wdata1 : wdata0;
  assign sel_col_bad = (int'(sel_col) >= B);

  // OTP bits can only be set, so already-set bits beyond wd are harmless.
  assign verify_pass = ((otp_data_out & wd_reg) == wd_reg);

  // Next-state and registered-output logic
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    retry_next     = retry_reg;
    id_next        = id_reg;
    last_id_next   = last_id_reg;
    col_next       = col_reg;
    wd_next        = wd_reg;
    gnt_next       = 2'b00;
    rsp_valid_next = 1'b0;
    rsp_id_next    = 1'b0;
    rsp_rdata_next = '0;
    rsp_err_next   = 1'b0;
    wsucc_next     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (|req) begin
          gnt_next     = win ? 2'b10 : 2'b01;
          id_next      = win;
          last_id_next = win;
          cnt_next     = '0;
          retry_next   = '0;
          if (sel_col_bad) begin
            // Never touches the array: respond in the grant cycle.
            state_next     = RESP;
            rsp_valid_next = 1'b1;
            rsp_id_next    = win;
            rsp_err_next   = 1'b1;
          end else begin
            col_next = sel_col;
            if (sel_we) begin
              wd_next    = sel_wd;
              state_next = PROG;
            end else begin
              state_next = READ;
            end
          end
        end
      end

      PROG: begin
        if (cnt_reg == CNT_W'(PULSE_CYCLES - 1)) begin
          cnt_next   = '0;
          state_next = VERIFY;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      VERIFY: begin
        if (cnt_reg == CNT_W'(READ_CYCLES - 1)) begin
          cnt_next = '0;
          if (verify_pass) begin
            state_next     = RESP;
            rsp_valid_next = 1'b1;
            rsp_id_next    = id_reg;
            rsp_rdata_next = otp_data_out;
            wsucc_next     = 1'b1;
          end else if (int'(retry_reg) < MAX_RETRY) begin
            retry_next = retry_reg + RETRY_W'(1);
            state_next = PROG;
          end else begin
            state_next     = RESP;
            rsp_valid_next = 1'b1;
            rsp_id_next    = id_reg;
            rsp_rdata_next = otp_data_out;
            rsp_err_next   = 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      READ: begin
        if (cnt_reg == CNT_W'(READ_CYCLES - 1)) begin
          cnt_next       = '0;
          state_next     = RESP;
          rsp_valid_next = 1'b1;
          rsp_id_next    = id_reg;
          rsp_rdata_next = otp_data_out;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      RESP: begin
        // One idle cycle with otp_mode=0 separates consecutive operations.
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      retry_reg     <= '0;
      id_reg        <= 1'b0;
      last_id_reg   <= 1'b1;
      col_reg       <= '0;
      wd_reg        <= '0;
      gnt_reg       <= 2'b00;
      rsp_valid_reg <= 1'b0;
      rsp_id_reg    <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
      wsucc_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      retry_reg     <= retry_next;
      id_reg        <= id_next;
      last_id_reg   <= last_id_next;
      col_reg       <= col_next;
      wd_reg        <= wd_next;
      gnt_reg       <= gnt_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_id_reg    <= rsp_id_next;
      rsp_rdata_reg <= rsp_rdata_next;
      rsp_err_reg   <= rsp_err_next;
      wsucc_reg     <= wsucc_next;
    end
  end

  // Mode is a pure decode of the state register, so an asynchronous reset
  // drops it to idle immediately, even in the middle of a pulse.
  always_comb begin
    otp_mode = 2'd0;
    case (state_reg)
      PROG:    otp_mode = 2'd1;
      VERIFY:  otp_mode = 2'd2;
      READ:    otp_mode = 2'd2;
      default: otp_mode = 2'd0;
    endcase
  end

  assign gnt                    = gnt_reg;
  assign rsp_valid              = rsp_valid_reg;
  assign rsp_id                 = rsp_id_reg;
  assign rsp_rdata              = rsp_rdata_reg;
  assign rsp_err                = rsp_err_reg;
  assign otp_column             = col_reg;
  assign otp_data_in            = wd_reg;
  assign otp_writing_successful = wsucc_reg;

endmodule

// File: tb/tb_otp_access_sequencer.sv
module tb_otp_access_sequencer;

  logic       clk;
  logic       reset;
  logic [1:0] req, we;
  logic [0:0] col0, col1;
  logic [1:0] wdata0, wdata1;
  logic [1:0] gnt;
  logic       rsp_valid, rsp_id, rsp_err;
  logic [1:0] rsp_rdata;
  logic [1:0] otp_mode;
  logic [0:0] otp_column;
  logic [1:0] otp_data_in;
  logic       otp_writing_successful;
  logic [1:0] otp_data_out;

  // Second instance with three columns for the out-of-range column case
  logic [1:0] req3, we3;
  logic [1:0] col3_0, col3_1;
  logic [1:0] wdata3_0, wdata3_1;
  logic [1:0] gnt3;
  logic       rsp_valid3, rsp_id3, rsp_err3;
  logic [1:0] rsp_rdata3;
  logic [1:0] otp_mode3;
  logic [1:0] otp_column3;
  logic [1:0] otp_data_in3;
  logic       otp_writing_successful3;
  logic [1:0] otp_data_out3;

  int checks = 0;
  int errors = 0;

  otp_access_sequencer dut (
    .clk(clk), .reset(reset), .req(req), .we(we),
    .col0(col0), .col1(col1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .otp_mode(otp_mode), .otp_column(otp_column), .otp_data_in(otp_data_in),
    .otp_writing_successful(otp_writing_successful),
    .otp_data_out(otp_data_out)
  );

  otp_access_sequencer #(.B(3)) dut3 (
    .clk(clk), .reset(reset), .req(req3), .we(we3),
    .col0(col3_0), .col1(col3_1), .wdata0(wdata3_0), .wdata1(wdata3_1),
    .gnt(gnt3), .rsp_valid(rsp_valid3), .rsp_id(rsp_id3),
    .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3),
    .otp_mode(otp_mode3), .otp_column(otp_column3), .otp_data_in(otp_data_in3),
    .otp_writing_successful(otp_writing_successful3),
    .otp_data_out(otp_data_out3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // OTP array model: program pulses OR in the allowed bits of the data.
  logic [1:0] mem [2];
  logic [1:0] set_mask;
  logic       rd_override;
  logic [1:0] rd_value;

  always @(posedge clk) begin
    if (!reset) begin
      mem[0] <= 2'b00;
      mem[1] <= 2'b00;
    end else if (otp_mode == 2'd1) begin
      mem[otp_column] <= mem[otp_column] | (otp_data_in & set_mask);
    end
  end

  assign otp_data_out  = rd_override ? rd_value : mem[otp_column];
  assign otp_data_out3 = 2'b00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request on port p (edge 0 samples it) and observe cycles 1..N
  // until the response strobe, bounded by a cycle budget.
  task automatic run_op(input int p, input logic w, input logic c, input logic [1:0] d,
                        output logic [1:0] g1, output int rsp_cyc,
                        output int n_prog, output int n_read,
                        output int ws_cyc, output int ws_cnt,
                        output logic [1:0] rd, output logic er, output logic id);
    g1 = 2'b00; rsp_cyc = -1; n_prog = 0; n_read = 0;
    ws_cyc = -1; ws_cnt = 0; rd = 2'b00; er = 1'b0; id = 1'b0;
    @(negedge clk);
    if (p == 0) begin
      we[0] = w; col0 = c; wdata0 = d; req = 2'b01;
    end else begin
      we[1] = w; col1 = c; wdata1 = d; req = 2'b10;
    end
    @(posedge clk);
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        g1  = gnt;
        req = 2'b00;
      end
      if (otp_mode == 2'd1) n_prog++;
      if (otp_mode == 2'd2) n_read++;
      if (otp_writing_successful) begin
        ws_cyc = cyc;
        ws_cnt++;
      end
      if (rsp_valid) begin
        rsp_cyc = cyc;
        rd = rsp_rdata;
        er = rsp_err;
        id = rsp_id;
        break;
      end
    end
    $display("op port=%0d we=%0b col=%0d data=%0b: gnt=%b rsp_cycle=%0d prog=%0d read=%0d ws_cycle=%0d rdata=%b err=%0b",
             p, w, c, d, g1, rsp_cyc, n_prog, n_read, ws_cyc, rd, er);
  endtask

  logic [1:0] g1, rd;
  logic       er, id;
  int         rsp_cyc, n_prog, n_read, ws_cyc, ws_cnt;
  logic [1:0] gseq [4];
  int         gcyc [4];
  int         ng;
  logic [1:0] prev_mode;

  initial begin
    reset = 1'b0;
    req = 2'b00; we = 2'b00; col0 = 1'b0; col1 = 1'b0; wdata0 = 2'b00; wdata1 = 2'b00;
    req3 = 2'b00; we3 = 2'b00; col3_0 = 2'd0; col3_1 = 2'd0; wdata3_0 = 2'b00; wdata3_1 = 2'b00;
    set_mask = 2'b11; rd_override = 1'b0; rd_value = 2'b00;

    // ---- reset state ----
    repeat (2) @(negedge clk);
    chk("reset_mode", 32'(otp_mode), 32'd0);
    chk("reset_gnt", 32'(gnt), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_wsucc", 32'(otp_writing_successful), 32'd0);
    reset = 1'b1;
    $display("reset released");

    // ---- reset in the middle of a program pulse ----
    @(negedge clk);
    we[0] = 1'b1; col0 = 1'b1; wdata0 = 2'b11; req = 2'b01;
    @(posedge clk);
    @(negedge clk);               // cycle 1
    chk("midprog_gnt", 32'(gnt), 32'h1);
    req = 2'b00;
    @(negedge clk);               // cycle 2
    @(negedge clk);               // cycle 3
    chk("midprog_mode_before", 32'(otp_mode), 32'd1);
    chk("midprog_datain_before", 32'(otp_data_in), 32'h3);
    reset = 1'b0;
    #1;
    chk("midprog_mode_after", 32'(otp_mode), 32'd0);
    chk("midprog_datain_after", 32'(otp_data_in), 32'd0);
    chk("midprog_column_after", 32'(otp_column), 32'd0);
    $display("reset asserted mid-program: mode=%0d", otp_mode);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // ---- both ports request continuously: grants alternate 0,1,0,1 ----
    rd_override = 1'b1; rd_value = 2'b01;
    we = 2'b00; col0 = 1'b0; col1 = 1'b1;
    @(negedge clk);
    prev_mode = otp_mode;
    req = 2'b11;
    ng = 0;
    @(posedge clk);
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      if (gnt != 2'b00) begin
        if (ng < 4) begin
          gseq[ng] = gnt;
          gcyc[ng] = cyc;
          $display("grant %0d: gnt=%b cycle=%0d", ng, gnt, cyc);
          chk("rr_idle_before_gnt", 32'(prev_mode), 32'd0);
        end
        ng++;
        if (ng == 4) req = 2'b00;
      end
      prev_mode = otp_mode;
    end
    chk("rr_grant_count", 32'(ng), 32'd4);
    chk("rr_gnt0", 32'(gseq[0]), 32'h1);
    chk("rr_gnt1", 32'(gseq[1]), 32'h2);
    chk("rr_gnt2", 32'(gseq[2]), 32'h1);
    chk("rr_gnt3", 32'(gseq[3]), 32'h2);
    chk("rr_gnt_cycle1", 32'(gcyc[1]), 32'd7);
    chk("rr_gnt_cycle3", 32'(gcyc[3]), 32'd19);

    // ---- port 0 read, column 1, FSM returns 2'b10 ----
    rd_value = 2'b10;
    run_op(0, 1'b0, 1'b1, 2'b00, g1, rsp_cyc, n_prog, n_read, ws_cyc, ws_cnt, rd, er, id);
    chk("read_gnt", 32'(g1), 32'h1);
    chk("read_rsp_cycle", 32'(rsp_cyc), 32'd5);
    chk("read_mode2_cycles", 32'(n_read), 32'd4);
    chk("read_mode1_cycles", 32'(n_prog), 32'd0);
    chk("read_rdata", 32'(rd), 32'h2);
    chk("read_err", 32'(er), 32'd0);
    chk("read_id", 32'(id), 32'd0);
    @(negedge clk);
    chk("read_rsp_cleared", 32'(rsp_valid), 32'd0);

    // ---- port 1 write 2'b11 to column 0, bits set on first pulse ----
    rd_override = 1'b0; set_mask = 2'b11;
    run_op(1, 1'b1, 1'b0, 2'b11, g1, rsp_cyc, n_prog, n_read, ws_cyc, ws_cnt, rd, er, id);
    chk("wr_gnt", 32'(g1), 32'h2);
    chk("wr_rsp_cycle", 32'(rsp_cyc), 32'd13);
    chk("wr_mode1_cycles", 32'(n_prog), 32'd8);
    chk("wr_mode2_cycles", 32'(n_read), 32'd4);
    chk("wr_wsucc_cycle", 32'(ws_cyc), 32'd13);
    chk("wr_err", 32'(er), 32'd0);
    chk("wr_rdata", 32'(rd), 32'h3);
    chk("wr_id", 32'(id), 32'd1);

    // ---- port 0 write 2'b01, bit 0 never programs: all retries fail ----
    set_mask = 2'b10;
    run_op(0, 1'b1, 1'b1, 2'b01, g1, rsp_cyc, n_prog, n_read, ws_cyc, ws_cnt, rd, er, id);
    chk("fail_gnt", 32'(g1), 32'h1);
    chk("fail_rsp_cycle", 32'(rsp_cyc), 32'd49);
    chk("fail_mode1_cycles", 32'(n_prog), 32'd32);
    chk("fail_mode2_cycles", 32'(n_read), 32'd16);
    chk("fail_wsucc_count", 32'(ws_cnt), 32'd0);
    chk("fail_err", 32'(er), 32'd1);
    chk("fail_rdata", 32'(rd), 32'h0);

    // ---- three-column instance, port 0 requests column 3 ----
    @(negedge clk);
    we3 = 2'b00; col3_0 = 2'd3; req3 = 2'b01;
    @(posedge clk);
    @(negedge clk);               // cycle 1
    $display("bad column: gnt=%b rsp_valid=%0b err=%0b rdata=%b mode=%0d",
             gnt3, rsp_valid3, rsp_err3, rsp_rdata3, otp_mode3);
    chk("badcol_gnt", 32'(gnt3), 32'h1);
    chk("badcol_rsp_valid", 32'(rsp_valid3), 32'd1);
    chk("badcol_err", 32'(rsp_err3), 32'd1);
    chk("badcol_rdata", 32'(rsp_rdata3), 32'd0);
    chk("badcol_mode", 32'(otp_mode3), 32'd0);
    req3 = 2'b00;
    @(negedge clk);               // cycle 2
    chk("badcol_mode_next", 32'(otp_mode3), 32'd0);
    chk("badcol_rsp_cleared", 32'(rsp_valid3), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
